// File: rtl/hazard_unit.sv
// hazard_unit -- pipeline hazard controller for the 5-stage RV32IM core.
//
// Purpose:
//   * EX-stage forwarding selects (ForwardAE / ForwardBE), one selector per
//     operand, both built from the same operand-lane sub-module.
//   * Load-use stall and taken-branch flush control.
//   * Multi-cycle EX occupancy for MUL/DIV via a two-state FSM plus counter.
//
// Ports:
//   clk, rst_n                       core clock, async active-low reset
//   Rs1_D, Rs2_D                     source registers of the ID instruction
//   Rs1_E, Rs2_E, Rd_E               source/dest registers of the EX instruction
//   Rd_M, RegWrite_M                 MEM destination and write enable
//   Rd_W, RegWrite_W, MemToReg_W     WB destination, write enable, load result
//   MemRead_E                        EX instruction is a load
//   PCSrc_E                          branch taken / jump resolved in EX
//   Mul_en_E, Div_en_E               EX holds a MUL / DIV-REM instruction
//   ForwardAE, ForwardBE             operand forward selects
//                                    (00 RF, 10 ALU_out_M, 01 mem data W, 11 ALU_out_W)
//   StallF, StallD, StallE           hold PC, IF/ID, ID/EX
//   FlushD, FlushE, FlushM           clear IF/ID, ID/EX, EX/MEM
//   MOpCapture_E                     one-cycle pulse: EX latches its operands

// Forward select for a single EX operand.
module hazard_fwd_sel (
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    input  logic       mem_to_reg_w,
    output logic [1:0] sel
);
    logic hit_m;
    logic hit_w;

    // x0 is hard-wired zero, so a write to it never produces a forward.
    assign hit_m = reg_write_m && (rd_m != 5'd0) && (rd_m == rs);
    assign hit_w = reg_write_w && (rd_w != 5'd0) && (rd_w == rs);

    always_comb begin
        sel = 2'b00;
        if (hit_m)
            sel = 2'b10;            // youngest producer wins
        else if (hit_w)
            sel = mem_to_reg_w ? 2'b01 : 2'b11;
    end
endmodule

module hazard_unit #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs1_D,
    input  logic [4:0] Rs2_D,
    input  logic [4:0] Rs1_E,
    input  logic [4:0] Rs2_E,
    input  logic [4:0] Rd_E,
    input  logic [4:0] Rd_M,
    input  logic [4:0] Rd_W,
    input  logic       RegWrite_M,
    input  logic       RegWrite_W,
    input  logic       MemRead_E,
    input  logic       MemToReg_W,
    input  logic       PCSrc_E,
    input  logic       Mul_en_E,
    input  logic       Div_en_E,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       MOpCapture_E
);
    localparam int NUM_OPS = 2;

    // The counter is 4 bits wide; latencies outside 1..15 cannot be sequenced.
    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
        $error("hazard_unit: MUL_LAT must be in 1..15");
    end
    if (DIV_LAT < 1 || DIV_LAT > 15) begin : g_bad_div_lat
        $error("hazard_unit: DIV_LAT must be in 1..15");
    end

    localparam logic [3:0] MUL_L = 4'(MUL_LAT);
    localparam logic [3:0] DIV_L = 4'(DIV_LAT);

    // ------------------------------------------------------------------
    // Forwarding: one selector lane per EX operand.
    // ------------------------------------------------------------------
    logic [NUM_OPS-1:0][4:0] rs_e;
    logic [NUM_OPS-1:0][1:0] fwd;

    assign rs_e[0] = Rs1_E;
    assign rs_e[1] = Rs2_E;

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
        hazard_fwd_sel u_sel (
            .rs          (rs_e[i]),
            .rd_m        (Rd_M),
            .rd_w        (Rd_W),
            .reg_write_m (RegWrite_M),
            .reg_write_w (RegWrite_W),
            .mem_to_reg_w(MemToReg_W),
            .sel         (fwd[i])
        );
    end

    // ------------------------------------------------------------------
    // Load-use detection.
    // ------------------------------------------------------------------
    logic lw_stall;

    assign lw_stall = MemRead_E && (Rd_E != 5'd0) &&
                      ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

    // ------------------------------------------------------------------
    // M-unit sequencer. cnt counts EX cycles already spent by the current
    // M instruction; release happens in the cycle where cnt reaches LAT-1,
    // giving an EX residency of exactly LAT cycles.
    // ------------------------------------------------------------------
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } m_state_t;

    m_state_t   st, st_next;
    logic [3:0] cnt, cnt_next;
    logic [3:0] lat;
    logic       m_start;
    logic       m_stall;
    logic       m_cap;

    assign lat     = Div_en_E ? DIV_L : MUL_L;
    assign m_start = (st == IDLE) && (Mul_en_E || Div_en_E);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= IDLE;
            cnt <= 4'd0;
        end else begin
            st  <= st_next;
            cnt <= cnt_next;
        end
    end

    always_comb begin
        st_next  = st;
        cnt_next = cnt;
        m_stall  = 1'b0;
        m_cap    = 1'b0;
        case (st)
            IDLE: begin
                // Single-cycle ops pass through without touching the FSM.
                if (m_start && (lat > 4'd1)) begin
                    m_stall  = 1'b1;
                    m_cap    = 1'b1;
                    cnt_next = 4'd1;
                    st_next  = BUSY;
                end
            end
            BUSY: begin
                // '<' rather than '!=' so a corrupted cnt can never run past
                // LAT-1 and wrap; both agree for every legal cnt.
                if (cnt < lat - 4'd1) begin
                    m_stall  = 1'b1;
                    cnt_next = cnt + 4'd1;
                end else begin
                    st_next  = IDLE;
                    cnt_next = 4'd0;
                end
            end
            default: begin
                st_next  = IDLE;
                cnt_next = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output combine. mStall dominates: it freezes IF/ID/EX and injects a
    // bubble into MEM, so any flush or load-use action must wait for release.
    // Everything is gated by rst_n so outputs go quiet immediately on reset.
    // ------------------------------------------------------------------
    logic lw_act;
    logic br_act;

    assign lw_act = lw_stall && !m_stall;
    assign br_act = PCSrc_E  && !m_stall;

    assign ForwardAE    = rst_n ? fwd[0] : 2'b00;
    assign ForwardBE    = rst_n ? fwd[1] : 2'b00;
    assign StallF       = rst_n && (m_stall || lw_act);
    assign StallD       = rst_n && (m_stall || lw_act);
    assign StallE       = rst_n && m_stall;
    assign FlushM       = rst_n && m_stall;
    assign FlushD       = rst_n && br_act;
    // A load-use bubble and a branch flush both clear ID/EX.
    assign FlushE       = rst_n && (br_act || lw_act);
    assign MOpCapture_E = rst_n && m_cap;
endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios from the hazard
// rules plus a randomized run against a behavioural reference model.
module tb_hazard_unit;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 8;

    logic       clk;
    logic       rst_n;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic       RegWrite_M, RegWrite_W, MemRead_E, MemToReg_W, PCSrc_E;
    logic       Mul_en_E, Div_en_E;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MOpCapture_E;

    int total = 0;
    int bad   = 0;

    // Control outputs packed {StallF,StallD,StallE,FlushD,FlushE,FlushM,MOpCapture_E}
    logic [6:0] ctl;
    assign ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MOpCapture_E};

    localparam logic [6:0] C_IDLE   = 7'b000_0000;
    localparam logic [6:0] C_MCAP   = 7'b111_0011;
    localparam logic [6:0] C_MSTALL = 7'b111_0010;
    localparam logic [6:0] C_LW     = 7'b110_0100;
    localparam logic [6:0] C_BR     = 7'b000_1100;
    localparam logic [6:0] C_LWBR   = 7'b110_1100;

    hazard_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
        .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemRead_E(MemRead_E), .MemToReg_W(MemToReg_W), .PCSrc_E(PCSrc_E),
        .Mul_en_E(Mul_en_E), .Div_en_E(Div_en_E),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .MOpCapture_E(MOpCapture_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A taken branch can never coincide with an M-unit stall.
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (PCSrc_E && StallE) begin
                bad++;
                $display("FAIL pcsrc_mstall_excl: PCSrc_E=1 with StallE=1 at %0t", $time);
            end
        end
    end

    // ---------------- reference model ----------------
    // m_rem: EX cycles still owed by the resident M instruction after the
    // current one has finished (0 = no sequence in progress).
    int m_rem = 0;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWrite_M && Rd_M != 0 && Rd_M == rs) return 2'b10;
        if (RegWrite_W && Rd_W != 0 && Rd_W == rs) return MemToReg_W ? 2'b01 : 2'b11;
        return 2'b00;
    endfunction

    function automatic int ref_lat();
        return Div_en_E ? DIV_LAT : MUL_LAT;
    endfunction

    function automatic logic [6:0] ref_ctl();
        logic ms, cap, lw;
        if (m_rem > 0) begin
            ms  = (m_rem > 1);
            cap = 1'b0;
        end else begin
            ms  = (Mul_en_E || Div_en_E) && ref_lat() > 1;
            cap = ms;
        end
        lw = MemRead_E && Rd_E != 0 && (Rd_E == Rs1_D || Rd_E == Rs2_D);
        return {ms || lw, ms || lw, ms, !ms && PCSrc_E, !ms && (PCSrc_E || lw), ms, cap};
    endfunction

    // Advance the model across one rising edge using the inputs at that edge.
    task automatic model_step();
        if (m_rem > 0)
            m_rem = m_rem - 1;
        else if ((Mul_en_E || Div_en_E) && ref_lat() > 1)
            m_rem = ref_lat() - 1;
    endtask

    task automatic clear_inputs();
        Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; Rd_E = 0; Rd_M = 0; Rd_W = 0;
        RegWrite_M = 0; RegWrite_W = 0; MemRead_E = 0; MemToReg_W = 0;
        PCSrc_E = 0; Mul_en_E = 0; Div_en_E = 0;
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        Rs1_E = 5; Rs2_E = 6; Rd_M = 5; Rd_W = 6; RegWrite_M = 1; RegWrite_W = 1;
        MemRead_E = 1; Rd_E = 3; Rs1_D = 3; PCSrc_E = 1; Div_en_E = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (ForwardAE !== 2'b00) begin bad++; $display("FAIL reset_fwdA: got %b want 00", ForwardAE); end
        total++;
        if (ForwardBE !== 2'b00) begin bad++; $display("FAIL reset_fwdB: got %b want 00", ForwardBE); end
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL reset_ctl: got %b want %b", ctl, C_IDLE); end
        clear_inputs();
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL post_reset_idle: got %b want %b", ctl, C_IDLE); end
        m_rem = 0;
    endtask

    task automatic test_forward();
        @(posedge clk); #1;
        clear_inputs();
        Rs1_E = 5; Rd_M = 5; RegWrite_M = 1; Rd_W = 5; RegWrite_W = 1;
        @(negedge clk);
        total++;
        if (ForwardAE !== 2'b10) begin bad++; $display("FAIL fwd_mem_prio: got %b want 10", ForwardAE); end
        RegWrite_M = 0; #1;
        total++;
        if (ForwardAE !== 2'b11) begin bad++; $display("FAIL fwd_wb_alu: got %b want 11", ForwardAE); end
        MemToReg_W = 1; #1;
        total++;
        if (ForwardAE !== 2'b01) begin bad++; $display("FAIL fwd_wb_mem: got %b want 01", ForwardAE); end
        clear_inputs(); RegWrite_M = 1; RegWrite_W = 1; #1;
        total++;
        if (ForwardBE !== 2'b00) begin bad++; $display("FAIL fwd_x0: got %b want 00", ForwardBE); end
        Rs2_E = 9; Rd_W = 9; RegWrite_W = 0; Rd_M = 4; #1;
        total++;
        if (ForwardBE !== 2'b00) begin bad++; $display("FAIL fwd_no_we: got %b want 00", ForwardBE); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        @(posedge clk); #1;
        MemRead_E = 1; Rd_E = 7; Rs2_D = 7;
        @(negedge clk);
        total++;
        if (ctl !== C_LW) begin bad++; $display("FAIL lw_stall: got %b want %b", ctl, C_LW); end
        @(posedge clk); #1;
        MemRead_E = 0; Rd_E = 0;    // bubble now in EX
        @(negedge clk);
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL lw_one_cycle: got %b want %b", ctl, C_IDLE); end
        @(posedge clk); #1;
        MemRead_E = 1; Rd_E = 0; Rs1_D = 0; Rs2_D = 0;
        @(negedge clk);
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL lw_x0: got %b want %b", ctl, C_IDLE); end
        clear_inputs();
    endtask

    task automatic test_branch();
        @(posedge clk); #1;
        PCSrc_E = 1;
        @(negedge clk);
        total++;
        if (ctl !== C_BR) begin bad++; $display("FAIL branch_flush: got %b want %b", ctl, C_BR); end
        @(posedge clk); #1;
        MemRead_E = 1; Rd_E = 12; Rs1_D = 12;
        @(negedge clk);
        total++;
        if (ctl !== C_LWBR) begin bad++; $display("FAIL lw_and_branch: got %b want %b", ctl, C_LWBR); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    // Holds Div_en_E for 8 cycles, checking capture and stall cycle by cycle.
    task automatic run_div(input string tag);
        for (int k = 0; k < DIV_LAT; k++) begin
            @(posedge clk); #1;
            Div_en_E = 1;
            @(negedge clk);
            total++;
            if (ctl !== (k == 0 ? C_MCAP : (k < DIV_LAT - 1 ? C_MSTALL : C_IDLE))) begin
                bad++;
                $display("FAIL %s_cycle%0d: got %b want %b", tag, k, ctl,
                         k == 0 ? C_MCAP : (k < DIV_LAT - 1 ? C_MSTALL : C_IDLE));
            end
        end
    endtask

    task automatic test_back_to_back();
        run_div("div");
        @(posedge clk); #1;           // cycle 8: MUL enters EX on the release edge
        Div_en_E = 0; Mul_en_E = 1;
        @(negedge clk);
        total++;
        if (ctl !== C_MCAP) begin bad++; $display("FAIL b2b_mul_start: got %b want %b", ctl, C_MCAP); end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL b2b_mul_release: got %b want %b", ctl, C_IDLE); end
        @(posedge clk); #1;
        Mul_en_E = 0;
        @(negedge clk);
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL b2b_idle: got %b want %b", ctl, C_IDLE); end
    endtask

    task automatic test_lw_during_div();
        int flush_seen = 0;
        for (int k = 0; k < DIV_LAT - 1; k++) begin
            @(posedge clk); #1;
            Div_en_E = 1; MemRead_E = 1; Rd_E = 3; Rs1_D = 3;
            @(negedge clk);
            if (FlushE !== 1'b0 || StallE !== 1'b1) flush_seen++;
        end
        total++;
        if (flush_seen != 0) begin bad++; $display("FAIL lw_div_masked: bad cycles %0d want 0", flush_seen); end
        @(posedge clk); #1;           // release cycle: stall gone, load-use acts
        @(negedge clk);
        total++;
        if (ctl !== C_LW) begin bad++; $display("FAIL lw_after_release: got %b want %b", ctl, C_LW); end
        @(posedge clk); #1;
        Div_en_E = 0;
        @(negedge clk);
        total++;
        if (ctl !== C_LW) begin bad++; $display("FAIL lw_after_div: got %b want %b", ctl, C_LW); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            Div_en_E = 1; Rs1_E = 4; Rd_M = 4; RegWrite_M = 1;
        end
        @(negedge clk); #2;           // mid-cycle 4, away from any edge
        rst_n = 1'b0;
        #1;
        total++;
        if (ctl !== C_IDLE || ForwardAE !== 2'b00) begin
            bad++; $display("FAIL async_reset: ctl %b fwdA %b want 0000000 00", ctl, ForwardAE);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        run_div("div_restart");
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL restart_idle: got %b want %b", ctl, C_IDLE); end
        m_rem = 0;
    endtask

    // ---------------- randomized run ----------------
    task automatic test_random(input int cycles);
        int kind = 0;
        int errs = 0;
        logic [6:0] ec;
        logic [1:0] ea, eb;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            model_step();
            #1;
            Rs1_D = 5'($urandom_range(0, 3)); Rs2_D = 5'($urandom_range(0, 3));
            Rs1_E = 5'($urandom_range(0, 3)); Rs2_E = 5'($urandom_range(0, 3));
            Rd_E  = 5'($urandom_range(0, 3)); Rd_M  = 5'($urandom_range(0, 3));
            Rd_W  = 5'($urandom_range(0, 3));
            RegWrite_M = 1'($urandom); RegWrite_W = 1'($urandom);
            MemRead_E  = 1'($urandom); MemToReg_W = 1'($urandom);
            if (m_rem == 0) begin
                kind = $urandom_range(0, 9);
                kind = (kind < 7) ? 0 : (kind < 9 ? 1 : 2);
            end
            Mul_en_E = (kind == 1);
            Div_en_E = (kind == 2);
            PCSrc_E = 1'b0;
            if (ref_ctl() ==? 7'b??0_????)   // no M stall this cycle
                PCSrc_E = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            ec = ref_ctl(); ea = ref_fwd(Rs1_E); eb = ref_fwd(Rs2_E);
            total++;
            if (ctl !== ec || ForwardAE !== ea || ForwardBE !== eb) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_c%0d: ctl %b fwdA %b fwdB %b want %b %b %b",
                             n, ctl, ForwardAE, ForwardBE, ec, ea, eb);
            end
        end
        @(posedge clk);
        model_step();
        #1;
        clear_inputs();
        // drain any sequence still running
        for (int n = 0; n < 20 && m_rem > 0; n++) begin
            @(posedge clk);
            model_step();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_lw_during_div();
        test_async_reset();
        test_random(400);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32IM core.
- Generates the ForwardAE/ForwardBE select codes consumed by the EX-stage forwarding muxes.
- Generates the stall and flush controls for load-use hazards and taken branches/jumps.
- Sequences multi-cycle occupancy of EX by MUL/DIV instructions with a small state machine and cycle counter.

Parameters:
- MUL_LAT, 2, cycles a MUL-class instruction occupies EX (1 to 15).
- DIV_LAT, 8, cycles a DIV/REM-class instruction occupies EX (1 to 15).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Rs1_D  input  5  rs1 of the instruction in ID.
- Rs2_D  input  5  rs2 of the instruction in ID.
- Rs1_E  input  5  rs1 of the instruction in EX.
- Rs2_E  input  5  rs2 of the instruction in EX.
- Rd_E  input  5  destination register of EX.
- Rd_M  input  5  destination register of MEM.
- Rd_W  input  5  destination register of WB.
- RegWrite_M  input  1  MEM instruction writes the register file.
- RegWrite_W  input  1  WB instruction writes the register file.
- MemRead_E  input  1  EX instruction is a load.
- MemToReg_W  input  1  WB result comes from data memory.
- PCSrc_E  input  1  branch taken or jump resolved in EX.
- Mul_en_E  input  1  EX holds a MUL-class instruction.
- Div_en_E  input  1  EX holds a DIV/REM-class instruction.
- ForwardAE  output  2  operand-1 forward select.
- ForwardBE  output  2  operand-2 forward select.
- StallF  output  1  hold the PC.
- StallD  output  1  hold the IF/ID register.
- StallE  output  1  hold the ID/EX register.
- FlushD  output  1  clear the IF/ID register.
- FlushE  output  1  clear the ID/EX register.
- FlushM  output  1  clear the EX/MEM register (bubble).
- MOpCapture_E  output  1  one-cycle pulse; EX latches its forwarded operands.

Behaviour:
- Forwarding is combinational and is evaluated independently for operand A (Rs1_E) and operand B (Rs2_E).
  - 2'b10 (ALU_out_M): RegWrite_M && Rd_M != 0 && Rd_M == Rs_E.
  - Otherwise, 2'b01 (mem_read_data_W): RegWrite_W && Rd_W != 0 && Rd_W == Rs_E && MemToReg_W.
  - Otherwise, 2'b11 (ALU_out_W): same match condition as 2'b01 but with !MemToReg_W.
  - Otherwise, 2'b00 (register file).
  - MEM takes priority over WB. x0 never forwards.
- Load-use hazard: lwStall = MemRead_E && Rd_E != 0 && (Rd_E == Rs1_D || Rd_E == Rs2_D).
  - lwStall asserts StallF, StallD and FlushE.
- Branch: PCSrc_E asserts FlushD and FlushE.
- M-unit FSM state: st (IDLE/BUSY) plus cnt[3:0].
  - LAT = DIV_LAT if Div_en_E, else MUL_LAT.
  - mStart = (st == IDLE) && (Mul_en_E || Div_en_E).
  - IDLE, with mStart and LAT > 1:
    - mStall = 1; MOpCapture_E = 1.
    - Next: cnt <= 1, st <= BUSY.
    - With LAT == 1: no stall, no state change.
  - BUSY, with cnt != LAT-1:
    - mStall = 1; next cnt <= cnt + 1.
  - BUSY, with cnt == LAT-1:
    - mStall = 0; next st <= IDLE, cnt <= 0.
    - The instruction advances at this edge.
  - EX residency is exactly LAT cycles.
  - A back-to-back M instruction entering EX on the release edge starts a fresh sequence in the next cycle (that cycle sees IDLE).
- mStall asserts StallF, StallD, StallE and FlushM.
- mStall overrides everything else:
  - FlushE = 0 and FlushD = 0 while mStall.
  - lwStall is not acted upon while mStall; it re-evaluates after release.
- PCSrc_E and mStall are mutually exclusive by construction. A bench assertion flags violation.
- Simultaneous lwStall and PCSrc_E: FlushD = 1, FlushE = 1, StallF = 1, StallD = 1. The flush wins at IF/ID.
- Reset (rst_n = 0, asynchronous):
  - st <= IDLE, cnt <= 0.
  - All stall, flush and MOpCapture_E outputs forced to 0.
  - ForwardAE and ForwardBE forced to 2'b00.
- Reset asserted mid-BUSY aborts the sequence immediately. After release the FSM is IDLE.
- cnt never wraps. A parameter outside 1..15 is an elaboration error.

Test Plan:
- Forward select priority:
  - Rs1_E = 5, Rd_M = 5, RegWrite_M = 1, and Rd_W = 5, RegWrite_W = 1 -> ForwardAE = 10.
  - Drop RegWrite_M -> ForwardAE = 11.
  - Then set MemToReg_W = 1 -> ForwardAE = 01.
  - Rs2_E = 0 with all Rd = 0 -> ForwardBE = 00.
- Load-use: MemRead_E = 1, Rd_E = 7, Rs2_D = 7 -> StallF = StallD = FlushE = 1 for exactly 1 cycle.
  - With Rd_E = 0, all three stay 0.
- Branch: PCSrc_E = 1 -> FlushD = FlushE = 1 in the same cycle; no stalls.
- DIV with DIV_LAT = 8: Div_en_E held high ->
  - MOpCapture_E pulses in cycle 0.
  - StallF/D/E and FlushM are high for cycles 0-6 and low in cycle 7.
  - The FSM is IDLE in cycle 8.
  - A back-to-back MUL (MUL_LAT = 2) then stalls exactly 1 cycle.
- Interaction: a load-use condition on the ID operands during DIV BUSY ->
  - FlushE stays 0 for the whole DIV.
  - lwStall takes effect in the cycle after release.
- Asynchronous reset at cnt = 4 during DIV -> all outputs 0 immediately (no clock edge needed); st = IDLE, cnt = 0.
  - Reapplied Div_en_E restarts the full 8-cycle sequence.
